// File: rtl/fir_seq_ctrl.sv
// Sequencer for a single-MAC, time-multiplexed FIR: circular history RAM, coefficient ROM and MAC strobes.
// Optional macro FIR_OVERRUN_EN adds clear_ovr/overrun, a sticky flag for samples offered while not ready.
module fir_seq_ctrl #(
  parameter int TAPS    = 8,
  parameter int ADDR_W  = 3,
  parameter int MAC_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic              flush,
  output logic [ADDR_W-1:0] rom_address,
  output logic [ADDR_W-1:0] ram_address,
  output logic              we,
  output logic              zero_sel,
  output logic              en,
  output logic              mac_init,
  output logic              mac_last,
`ifdef FIR_OVERRUN_EN
  input  logic              clear_ovr,
  output logic              overrun,
`endif
  output logic              valid_out
);

  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(TAPS - 1);
  localparam logic [ADDR_W-1:0] TAPS_M = ADDR_W'(TAPS);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
  localparam logic [2:0]        LAT_W  = 3'(MAC_LAT);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d, wr_ptr_q, wr_ptr_d, k_nxt;
  logic [2:0]        lat_q, lat_d;
  logic              ready_q, ready_d, we_q, we_d, zero_q, zero_d, en_q, en_d;
  logic              init_q, init_d, last_q, last_d, vout_q, vout_d;
  logic [ADDR_W-1:0] rom_q, rom_d, ram_q, ram_d;
`ifdef FIR_OVERRUN_EN
  logic              ovr_q, ovr_d;
`endif

  // (wp - k) mod TAPS; the wrapped sum is always below TAPS, so ADDR_W-bit arithmetic is exact.
  function automatic logic [ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] wp,
                                                 input logic [ADDR_W-1:0] k);
    logic [ADDR_W-1:0] res;
    if (wp >= k) begin
      res = wp - k;
    end else begin
      res = wp + TAPS_M - k;
    end
    return res;
  endfunction

  assign k_nxt = k_q + ONE;

  // Next state and the next value of every registered output.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    lat_d    = lat_q;
    wr_ptr_d = wr_ptr_q;
    ready_d  = 1'b0;
    rom_d    = '0;
    ram_d    = '0;
    we_d     = 1'b0;
    zero_d   = 1'b0;
    en_d     = 1'b0;
    init_d   = 1'b0;
    last_d   = 1'b0;
    vout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = FLUSH;
          k_d     = '0;
          we_d    = 1'b1;
          zero_d  = 1'b1;
        end else if (valid_in && ready_q) begin
          state_d = ACCUM;
          k_d     = '0;
          en_d    = 1'b1;
          we_d    = 1'b1;
          init_d  = 1'b1;
          ram_d   = wr_ptr_q;
        end else begin
          ready_d = 1'b1;
        end
      end
      ACCUM: begin
        if (k_q == LAST_K) begin
          wr_ptr_d = (wr_ptr_q == LAST_K) ? '0 : wr_ptr_q + ONE;
          if (MAC_LAT == 0) begin
            state_d = IDLE;
            vout_d  = 1'b1;
            ready_d = 1'b1;
          end else begin
            state_d = DRAIN;
            lat_d   = 3'd1;
          end
        end else begin
          k_d    = k_nxt;
          en_d   = 1'b1;
          rom_d  = k_nxt;
          ram_d  = tap_addr(wr_ptr_q, k_nxt);
          last_d = (k_nxt == LAST_K);
        end
      end
      DRAIN: begin
        if (lat_q == LAT_W) begin
          state_d = IDLE;
          vout_d  = 1'b1;
          ready_d = 1'b1;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      FLUSH: begin
        if (k_q == LAST_K) begin
          state_d  = IDLE;
          wr_ptr_d = '0;
          ready_d  = 1'b1;
        end else begin
          k_d    = k_nxt;
          we_d   = 1'b1;
          zero_d = 1'b1;
          ram_d  = k_nxt;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

`ifdef FIR_OVERRUN_EN
  // Sticky overrun: a blocked offer sets it and takes priority over clear.
  always_comb begin
    ovr_d = ovr_q;
    if (valid_in && !ready_q) begin
      ovr_d = 1'b1;
    end else if (clear_ovr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Overrun flag register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign overrun = ovr_q;
`endif

  // State, counters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      lat_q    <= 3'd0;
      wr_ptr_q <= '0;
      ready_q  <= 1'b0;
      rom_q    <= '0;
      ram_q    <= '0;
      we_q     <= 1'b0;
      zero_q   <= 1'b0;
      en_q     <= 1'b0;
      init_q   <= 1'b0;
      last_q   <= 1'b0;
      vout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      lat_q    <= lat_d;
      wr_ptr_q <= wr_ptr_d;
      ready_q  <= ready_d;
      rom_q    <= rom_d;
      ram_q    <= ram_d;
      we_q     <= we_d;
      zero_q   <= zero_d;
      en_q     <= en_d;
      init_q   <= init_d;
      last_q   <= last_d;
      vout_q   <= vout_d;
    end
  end

  assign ready_in    = ready_q;
  assign rom_address = rom_q;
  assign ram_address = ram_q;
  assign we          = we_q;
  assign zero_sel    = zero_q;
  assign en          = en_q;
  assign mac_init    = init_q;
  assign mac_last    = last_q;
  assign valid_out   = vout_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl: 8-tap/MAC_LAT=2 instance plus a 5-tap/MAC_LAT=0 instance.
module tb_fir_seq_ctrl;
  logic clock = 1'b0, reset = 1'b1, valid_in = 1'b0, flush = 1'b0, valid5 = 1'b0;
  logic clear_ovr = 1'b0;
  logic ready_in, we, zero_sel, en, mac_init, mac_last, valid_out;
  logic [2:0] rom_address, ram_address;
  logic ready5, we5, zero5, en5, init5, last5, vout5;
  logic [2:0] rom5, ram5;
  logic overrun, overrun5;
  int n_cmp = 0, n_bad = 0;

  always #5 clock = ~clock;

  fir_seq_ctrl #(.TAPS(8), .ADDR_W(3), .MAC_LAT(2)) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .ready_in(ready_in), .flush(flush),
    .rom_address(rom_address), .ram_address(ram_address), .we(we), .zero_sel(zero_sel),
    .en(en), .mac_init(mac_init), .mac_last(mac_last),
`ifdef FIR_OVERRUN_EN
    .clear_ovr(clear_ovr), .overrun(overrun),
`endif
    .valid_out(valid_out));

  fir_seq_ctrl #(.TAPS(5), .ADDR_W(3), .MAC_LAT(0)) dut5 (
    .clock(clock), .reset(reset), .valid_in(valid5), .ready_in(ready5), .flush(1'b0),
    .rom_address(rom5), .ram_address(ram5), .we(we5), .zero_sel(zero5),
    .en(en5), .mac_init(init5), .mac_last(last5),
`ifdef FIR_OVERRUN_EN
    .clear_ovr(clear_ovr), .overrun(overrun5),
`endif
    .valid_out(vout5));

`ifndef FIR_OVERRUN_EN
  assign overrun  = 1'b0;
  assign overrun5 = 1'b0;
`endif

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_quiet(input string tag, input logic exp_ready);
    check_val({tag, "_rdy"}, ready_in, exp_ready);
    check_val({tag, "_rom"}, rom_address, 0);
    check_val({tag, "_ram"}, ram_address, 0);
    check_val({tag, "_we"}, we, 0);
    check_val({tag, "_zero"}, zero_sel, 0);
    check_val({tag, "_en"}, en, 0);
    check_val({tag, "_init"}, mac_init, 0);
    check_val({tag, "_last"}, mac_last, 0);
    check_val({tag, "_vout"}, valid_out, 0);
  endtask

  // One sample on the 8-tap instance; returns positioned on its valid_out cycle.
  task automatic send8(input int wp);
    check_val("s8_rdy_pre", ready_in, 1);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_val("s8_en", en, 1);
      check_val("s8_rom", rom_address, k);
      check_val("s8_ram", ram_address, (wp - k + 8) % 8);
      check_val("s8_we", we, k == 0);
      check_val("s8_init", mac_init, k == 0);
      check_val("s8_last", mac_last, k == 7);
      check_val("s8_rdy_acc", ready_in, 0);
      check_val("s8_vout_acc", valid_out, 0);
      tick();
    end
    for (int c = 8; c <= 10; c++) begin
      check_val("s8_vout", valid_out, c == 10);
      check_val("s8_en_drain", en, 0);
      check_val("s8_rdy_drain", ready_in, c == 10);
      if (c < 10) tick();
    end
  endtask

  // One sample on the 5-tap, zero-latency instance.
  task automatic send5(input int wp);
    check_val("s5_rdy_pre", ready5, 1);
    valid5 = 1'b1;
    tick();
    valid5 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check_val("s5_en", en5, 1);
      check_val("s5_rom", rom5, k);
      check_val("s5_ram", ram5, (wp - k + 5) % 5);
      check_val("s5_ram_le4", ram5 <= 3'd4, 1);
      check_val("s5_init", init5, k == 0);
      check_val("s5_last", last5, k == 4);
      check_val("s5_vout_acc", vout5, 0);
      tick();
    end
    check_val("s5_vout", vout5, 1);
    check_val("s5_en_end", en5, 0);
    check_val("s5_rdy_end", ready5, 1);
  endtask

  initial begin
    repeat (2) tick();
    check_quiet("rst", 1'b0);
    reset = 1'b0;
    tick();
    check_quiet("post_rst", 1'b1);

    // Basic output followed by back-to-back samples wrapping the write pointer.
    for (int s = 0; s < 9; s++) send8(s % 8);
    tick();
    check_quiet("after_wrap", 1'b1);

    // Handshake with valid_in held high: acceptance every 11 cycles.
    check_val("ovr_init", overrun, 0);
    valid_in = 1'b1;
    for (int c = 0; c <= 22; c++) begin
      check_val("hs_rdy", ready_in, (c % 11) == 0);
`ifdef FIR_OVERRUN_EN
      if (c == 3) check_val("ovr_set", overrun, 1);
`endif
      if (c == 22) valid_in = 1'b0;
      tick();
    end
`ifdef FIR_OVERRUN_EN
    clear_ovr = 1'b1;
    check_val("ovr_hold", overrun, 1);
    tick();
    clear_ovr = 1'b0;
    check_val("ovr_clr", overrun, 0);
`endif

    // Flush and valid_in together: flush wins and valid_in is ignored throughout.
    flush    = 1'b1;
    valid_in = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_val("fl_we", we, 1);
      check_val("fl_zero", zero_sel, 1);
      check_val("fl_en", en, 0);
      check_val("fl_ram", ram_address, i);
      check_val("fl_rdy", ready_in, 0);
      if (i == 7) valid_in = 1'b0;
      tick();
    end
    check_quiet("fl_done", 1'b1);
    send8(0);
    tick();

    // Reset asserted mid-ACCUM at tap 3 (write pointer is 1 here).
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    repeat (3) tick();
    check_val("mid_rom", rom_address, 3);
    check_val("mid_ram", ram_address, 6);
    #2;
    reset = 1'b1;
    #1;
    check_quiet("mid_rst", 1'b0);
    tick();
    check_quiet("mid_rst_edge", 1'b0);
    reset = 1'b0;
    tick();
    check_quiet("mid_rel", 1'b1);
    send8(0);
    tick();

    // Non-power-of-two tap count with zero MAC latency.
    for (int s = 0; s < 6; s++) send5(s % 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
